yacht_game_ctrl: RTL and testbench
==================================

// Module: yacht_game_ctrl
// PURPOSE
//  Parametrised Yacht turn/round sequencer for NUM_PLAYERS players over NUM_CAT categories.
//  Sits between the debounced button front-end, the dice roller (roll_trigger) and the
//  category score calculator (calc_score); owns per-player used-category masks and totals.
//  Adds over the 2-player controller: N players, mandatory first roll, winner/tie and restart.
// PARAMETERS
//  NUM_PLAYERS  2   players, 2..4
//  NUM_CAT      12  categories per player = rounds per game, 2..15
//  MAX_ROLLS    3   rolls allowed per turn, 1..3
//  SCORE_W      8   width of calc_score
//  TOTAL_W      10  width of each player total
// PORTS
//  clk           in   1                   clock
//  reset_n       in   1                   async active-low reset
//  btn_roll      in   1                   1-cycle pulse: roll / restart in GAME_END
//  btn_sel       in   1                   1-cycle pulse: go to select / commit
//  btn_prev      in   1                   1-cycle pulse: previous free category
//  btn_next      in   1                   1-cycle pulse: next free category
//  calc_score    in   SCORE_W             score of category_idx for current dice
//  state         out  3                   current FSM state (yacht_pkg encoding)
//  player        out  2                   active player, 0-based
//  roll_trigger  out  1                   1-cycle pulse to dice roller
//  roll_cnt      out  2                   rolls used this turn
//  category_idx  out  4                   highlighted category
//  round_num     out  4                   1..NUM_CAT
//  scores        out  NUM_PLAYERS*TOTAL_W player p total at [p*TOTAL_W +: TOTAL_W]
//  game_over     out  1                   high in GAME_END
//  winner        out  2                   highest-total player, valid with game_over
//  tie           out  1                   >1 player shares highest total, valid with game_over
// BEHAVIOUR
//  Reset: state=INIT, all outputs 0 except round_num=1; masks cleared. Reset mid-game aborts.
//  States: INIT->TURN_START->WAIT->ROLL->{WAIT|SELECT}->SELECT->COMMIT->NEXT->{TURN_START|GAME_END}
//  INIT: clear totals, masks; round_num=1, player=0; -> TURN_START.
//  TURN_START: roll_cnt=0; category_idx=lowest free index of player mask; -> WAIT.
//  WAIT: btn_roll & roll_cnt<MAX_ROLLS -> ROLL; else btn_sel & roll_cnt>=1 -> SELECT;
//        btn_sel with roll_cnt==0 ignored; btn_roll and btn_sel together: roll wins.
//  ROLL (1 cycle): roll_cnt+1; roll_trigger registered high exactly the following cycle;
//        -> SELECT when new roll_cnt==MAX_ROLLS else -> WAIT.
//  SELECT: btn_next/btn_prev move to next/previous free category, wrap NUM_CAT-1<->0;
//        both same cycle: next wins; sole free category: idx unchanged;
//        btn_sel -> COMMIT (same-cycle move ignored).
//  COMMIT (1 cycle): total += calc_score, saturate at 2^TOTAL_W-1; mask[category_idx]=1.
//  NEXT: player<NUM_PLAYERS-1 -> player+1; else player=0 and round_num==NUM_CAT -> GAME_END,
//        else round_num+1; -> TURN_START.
//  GAME_END: game_over=1; winner=lowest index among max totals; tie set if shared.
//        btn_roll -> INIT (restart); other buttons ignored.
//  Latency: btn_roll in cycle N -> ROLL in N+1 -> roll_trigger in N+2.
// CONFIGURATION
//  YACHT_UPPER_BONUS_EN defined: per-player upper sum (categories 0..5) tracked; in COMMIT,
//   upper sum crossing >=63 adds +35 to total (same saturating add), once per player per game.
//  Undefined: no upper-sum registers, no bonus; totals are plain category sums.
// STRUCTURE
//  yacht_pkg: state encoding, UPPER_CNT=6, BONUS_THRESH=63, BONUS_PTS=35.
//  Sub-module yacht_free_cat_finder (combinational): mask, cur idx, dir -> first/next/prev free.
//  Masks/totals: arrays indexed by player; one mux selects active player's mask.
// TESTING
//  btn_sel in WAIT with roll_cnt=0 -> stays WAIT; then btn_roll -> roll_trigger 1 cycle, roll_cnt=1.
//  3x btn_roll (MAX_ROLLS=3) -> auto SELECT after 3rd ROLL; 4th btn_roll ignored, no trigger.
//  mask=12'b1111_1111_1110, idx 0: btn_next -> idx stays 0; mask bit 0,1 free, idx 1: btn_next -> 0.
//  NUM_PLAYERS=3: full game calc_score=5 -> game_over, all totals 60, tie=1, winner=0.
//  BONUS_EN: player 0 commits 20,20,23 upper -> total 98 (63+35); further upper commits no 2nd bonus.
//  reset_n low in SELECT of round 7 -> INIT values; btn_roll in GAME_END -> INIT, scores 0.

Source files
------------

// File: rtl/yacht_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : yacht_pkg
//  Description: Shared state encoding and scoring constants for the Yacht
//               turn/round sequencer.
//  Revision   : 1.0 - initial release
// ============================================================================
package yacht_pkg;

    // Sequencer state encoding, exported on the controller's state port
    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_TURN_START = 3'd1,
        ST_WAIT       = 3'd2,
        ST_ROLL       = 3'd3,
        ST_SELECT     = 3'd4,
        ST_COMMIT     = 3'd5,
        ST_NEXT       = 3'd6,
        ST_GAME_END   = 3'd7
    } state_t;

    // Upper section = categories 0..UPPER_CNT-1 (ones .. sixes)
    localparam int UPPER_CNT    = 6;
    localparam int BONUS_THRESH = 63;
    localparam int BONUS_PTS    = 35;

    // True when a category index falls in the upper section
    function automatic logic is_upper(input logic [3:0] idx);
        return (idx < 4'(UPPER_CNT));
    endfunction

endpackage
`default_nettype wire

// File: rtl/yacht_free_cat_finder.sv
`default_nettype none
// ============================================================================
//  Module     : yacht_free_cat_finder
//  Description: Combinational search over a used-category mask. Produces the
//               lowest free category and the next (dir=1) or previous (dir=0)
//               free category from cur_idx, wrapping around NUM_CAT. When no
//               other category is free the step result is cur_idx itself.
//  Revision   : 1.0 - initial release
// ============================================================================
module yacht_free_cat_finder #(
    parameter int NUM_CAT = 12
) (
    input  logic [NUM_CAT-1:0] mask,
    input  logic [3:0]         cur_idx,
    input  logic               dir,
    output logic [3:0]         first_free,
    output logic [3:0]         step_free
);

    logic w_first_found;
    logic w_step_found;
    int   w_cand;

    // Lowest clear bit of the mask; 0 if the mask is full
    always_comb begin
        first_free    = '0;
        w_first_found = 1'b0;
        for (int i = 0; i < NUM_CAT; i++) begin
            if (!w_first_found && !mask[i]) begin
                first_free    = 4'(i);
                w_first_found = 1'b1;
            end
        end
    end

    // Walk away from cur_idx in the requested direction, wrapping modulo NUM_CAT
    always_comb begin
        step_free    = cur_idx;
        w_step_found = 1'b0;
        w_cand       = 0;
        for (int k = 1; k < NUM_CAT; k++) begin
            w_cand = dir ? (int'(cur_idx) + k) : (int'(cur_idx) + NUM_CAT - k);
            if (w_cand >= NUM_CAT) begin
                w_cand = w_cand - NUM_CAT;
            end
            if (!w_step_found && !mask[w_cand[3:0]]) begin
                step_free    = w_cand[3:0];
                w_step_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/yacht_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : yacht_game_ctrl
//  Description: Yacht turn/round sequencer for NUM_PLAYERS players over
//               NUM_CAT categories. Drives the dice roller, tracks per-player
//               used-category masks and saturating totals, and reports the
//               winner / tie at game end. btn_roll in GAME_END restarts.
//  Options    : YACHT_UPPER_BONUS_EN - per-player upper-section sum; the
//               commit that brings it to >= 63 adds a one-time +35 bonus.
//  Revision   : 1.0 - initial release
// ============================================================================
module yacht_game_ctrl
    import yacht_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_CAT     = 12,
    parameter int MAX_ROLLS   = 3,
    parameter int SCORE_W     = 8,
    parameter int TOTAL_W     = 10
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           btn_roll,
    input  logic                           btn_sel,
    input  logic                           btn_prev,
    input  logic                           btn_next,
    input  logic [SCORE_W-1:0]             calc_score,
    output logic [2:0]                     state,
    output logic [1:0]                     player,
    output logic                           roll_trigger,
    output logic [1:0]                     roll_cnt,
    output logic [3:0]                     category_idx,
    output logic [3:0]                     round_num,
    output logic [NUM_PLAYERS*TOTAL_W-1:0] scores,
    output logic                           game_over,
    output logic [1:0]                     winner,
    output logic                           tie
);

    // Headroom for total + score + bonus before saturation
    localparam int c_SUM_W = ((TOTAL_W > SCORE_W) ? TOTAL_W : SCORE_W) + 2;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0] r_player;
    logic       r_roll_trig;
    logic [1:0] r_roll_cnt;
    logic [3:0] r_cat_idx;
    logic [3:0] r_round;

    // FSM action strobes
    logic w_clear;
    logic w_turn_start;
    logic w_do_roll;
    logic w_move;
    logic w_commit;
    logic w_advance;

    // Per-player state gathered into packed arrays for the active-player mux
    logic [NUM_PLAYERS-1:0][NUM_CAT-1:0] w_mask;
    logic [NUM_PLAYERS-1:0][TOTAL_W-1:0] w_tot;
    logic [NUM_CAT-1:0]                  w_act_mask;
    logic [TOTAL_W-1:0]                  w_act_total;

    logic [3:0]         w_first_free;
    logic [3:0]         w_step_free;
    logic [NUM_CAT-1:0] w_cat_onehot;
    logic [5:0]         w_bonus_pts;
    logic [c_SUM_W-1:0] w_sum;
    logic [TOTAL_W-1:0] w_total_new;

    logic [TOTAL_W-1:0] w_best;
    logic [1:0]         w_win;
    logic               w_tie;

    assign w_cat_onehot = {{(NUM_CAT-1){1'b0}}, 1'b1} << r_cat_idx;

    yacht_free_cat_finder #(
        .NUM_CAT    (NUM_CAT)
    ) u_finder (
        .mask       (w_act_mask),
        .cur_idx    (r_cat_idx),
        .dir        (btn_next),
        .first_free (w_first_free),
        .step_free  (w_step_free)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state action strobes
    always_comb begin
        w_state_nxt  = r_state;
        w_clear      = 1'b0;
        w_turn_start = 1'b0;
        w_do_roll    = 1'b0;
        w_move       = 1'b0;
        w_commit     = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_clear     = 1'b1;
                w_state_nxt = ST_TURN_START;
            end
            ST_TURN_START: begin
                w_turn_start = 1'b1;
                w_state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                // A roll request takes priority over a select request
                if (btn_roll && (r_roll_cnt < 2'(MAX_ROLLS))) begin
                    w_state_nxt = ST_ROLL;
                end else if (btn_sel && (r_roll_cnt != 2'd0)) begin
                    w_state_nxt = ST_SELECT;
                end
            end
            ST_ROLL: begin
                w_do_roll   = 1'b1;
                w_state_nxt = ((r_roll_cnt + 2'd1) == 2'(MAX_ROLLS)) ? ST_SELECT : ST_WAIT;
            end
            ST_SELECT: begin
                if (btn_sel) begin
                    w_state_nxt = ST_COMMIT;
                end else if (btn_next || btn_prev) begin
                    w_move = 1'b1;
                end
            end
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                w_advance = 1'b1;
                if ((r_player == 2'(NUM_PLAYERS-1)) && (r_round == 4'(NUM_CAT))) begin
                    w_state_nxt = ST_GAME_END;
                end else begin
                    w_state_nxt = ST_TURN_START;
                end
            end
            ST_GAME_END: begin
                // Restart clears the game on the way into INIT
                if (btn_roll) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_INIT;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Turn bookkeeping: player, round, roll count, highlighted category
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_player    <= '0;
            r_roll_trig <= 1'b0;
            r_roll_cnt  <= '0;
            r_cat_idx   <= '0;
            r_round     <= 4'd1;
        end else begin
            r_roll_trig <= w_do_roll;
            if (w_clear) begin
                r_player   <= '0;
                r_roll_cnt <= '0;
                r_cat_idx  <= '0;
                r_round    <= 4'd1;
            end
            if (w_turn_start) begin
                r_roll_cnt <= '0;
                r_cat_idx  <= w_first_free;
            end
            if (w_do_roll) begin
                r_roll_cnt <= r_roll_cnt + 2'd1;
            end
            if (w_move) begin
                r_cat_idx <= w_step_free;
            end
            if (w_advance) begin
                if (r_player == 2'(NUM_PLAYERS-1)) begin
                    r_player <= '0;
                    if (r_round != 4'(NUM_CAT)) begin
                        r_round <= r_round + 4'd1;
                    end
                end else begin
                    r_player <= r_player + 2'd1;
                end
            end
        end
    end

    // Active-player mask and total
    always_comb begin
        w_act_mask  = '0;
        w_act_total = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (r_player == 2'(p)) begin
                w_act_mask  = w_mask[p];
                w_act_total = w_tot[p];
            end
        end
    end

`ifdef YACHT_UPPER_BONUS_EN
    localparam int c_UP_W = SCORE_W + 3;

    logic [NUM_PLAYERS-1:0][c_UP_W-1:0] w_upper;
    logic [NUM_PLAYERS-1:0]             w_done;
    logic [c_UP_W-1:0]                  w_act_upper;
    logic                               w_act_done;
    logic                               w_is_upper;
    logic [c_UP_W-1:0]                  w_upper_new;
    logic                               w_bonus_hit;

    // Active-player upper sum and bonus-awarded flag
    always_comb begin
        w_act_upper = '0;
        w_act_done  = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (r_player == 2'(p)) begin
                w_act_upper = w_upper[p];
                w_act_done  = w_done[p];
            end
        end
    end

    assign w_is_upper  = is_upper(r_cat_idx);
    assign w_upper_new = w_act_upper + c_UP_W'(calc_score);
    assign w_bonus_hit = w_is_upper && !w_act_done && (w_upper_new >= c_UP_W'(BONUS_THRESH));
    assign w_bonus_pts = w_bonus_hit ? 6'(BONUS_PTS) : 6'd0;
`else
    assign w_bonus_pts = 6'd0;
`endif

    assign w_sum       = c_SUM_W'(w_act_total) + c_SUM_W'(calc_score) + c_SUM_W'(w_bonus_pts);
    assign w_total_new = (|w_sum[c_SUM_W-1:TOTAL_W]) ? {TOTAL_W{1'b1}} : w_sum[TOTAL_W-1:0];

    generate
        for (genvar gp = 0; gp < NUM_PLAYERS; gp++) begin : g_player
            logic [NUM_CAT-1:0] r_mask;
            logic [TOTAL_W-1:0] r_total;

            // Per-player used mask and running total, updated on this player's commit
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_mask  <= '0;
                    r_total <= '0;
                end else if (w_clear) begin
                    r_mask  <= '0;
                    r_total <= '0;
                end else if (w_commit && (r_player == 2'(gp))) begin
                    r_mask  <= r_mask | w_cat_onehot;
                    r_total <= w_total_new;
                end
            end

            assign w_mask[gp] = r_mask;
            assign w_tot[gp]  = r_total;

`ifdef YACHT_UPPER_BONUS_EN
            logic [c_UP_W-1:0] r_upper;
            logic              r_bonus_done;

            // Upper-section sum and one-shot bonus flag for this player
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_upper      <= '0;
                    r_bonus_done <= 1'b0;
                end else if (w_clear) begin
                    r_upper      <= '0;
                    r_bonus_done <= 1'b0;
                end else if (w_commit && (r_player == 2'(gp)) && w_is_upper) begin
                    r_upper <= w_upper_new;
                    if (w_bonus_hit) begin
                        r_bonus_done <= 1'b1;
                    end
                end
            end

            assign w_upper[gp] = r_upper;
            assign w_done[gp]  = r_bonus_done;
`endif
        end
    endgenerate

    // Highest total; ties resolve to the lowest player index
    always_comb begin
        w_best = w_tot[0];
        w_win  = '0;
        w_tie  = 1'b0;
        for (int p = 1; p < NUM_PLAYERS; p++) begin
            if (w_tot[p] > w_best) begin
                w_best = w_tot[p];
                w_win  = 2'(p);
                w_tie  = 1'b0;
            end else if (w_tot[p] == w_best) begin
                w_tie = 1'b1;
            end
        end
    end

    assign state        = r_state;
    assign player       = r_player;
    assign roll_trigger = r_roll_trig;
    assign roll_cnt     = r_roll_cnt;
    assign category_idx = r_cat_idx;
    assign round_num    = r_round;
    assign scores       = w_tot;
    assign game_over    = (r_state == ST_GAME_END);
    assign winner       = game_over ? w_win : 2'd0;
    assign tie          = game_over && w_tie;

endmodule
`default_nettype wire

// File: tb/tb_yacht_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : tb_yacht_game_ctrl
//  Description: Directed self-checking bench for yacht_game_ctrl with three
//               players, twelve categories and three rolls per turn.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_yacht_game_ctrl;
    import yacht_pkg::*;

    localparam int NP = 3;
    localparam int TW = 10;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           btn_roll = 1'b0;
    logic           btn_sel = 1'b0;
    logic           btn_prev = 1'b0;
    logic           btn_next = 1'b0;
    logic [7:0]     calc_score = 8'd0;
    logic [2:0]     state;
    logic [1:0]     player;
    logic           roll_trigger;
    logic [1:0]     roll_cnt;
    logic [3:0]     category_idx;
    logic [3:0]     round_num;
    logic [NP*TW-1:0] scores;
    logic           game_over;
    logic [1:0]     winner;
    logic           tie;

    int checks = 0;
    int errors = 0;

    yacht_game_ctrl #(
        .NUM_PLAYERS (NP),
        .NUM_CAT     (12),
        .MAX_ROLLS   (3),
        .SCORE_W     (8),
        .TOTAL_W     (TW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_roll     (btn_roll),
        .btn_sel      (btn_sel),
        .btn_prev     (btn_prev),
        .btn_next     (btn_next),
        .calc_score   (calc_score),
        .state        (state),
        .player       (player),
        .roll_trigger (roll_trigger),
        .roll_cnt     (roll_cnt),
        .category_idx (category_idx),
        .round_num    (round_num),
        .scores       (scores),
        .game_over    (game_over),
        .winner       (winner),
        .tie          (tie)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
            $error("%s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_roll();
        btn_roll = 1'b1; tick(); btn_roll = 1'b0;
    endtask

    task automatic press_sel();
        btn_sel = 1'b1; tick(); btn_sel = 1'b0;
    endtask

    task automatic press_next();
        btn_next = 1'b1; tick(); btn_next = 1'b0;
    endtask

    task automatic press_prev();
        btn_prev = 1'b1; tick(); btn_prev = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget);
        int n = 0;
        while (state !== st && n < budget) begin
            tick();
            n++;
        end
        check("wait_state", 32'(state), 32'(st));
    endtask

    // From WAIT after at least one roll: go to SELECT, commit sc, land in WAIT or GAME_END
    task automatic finish_turn(input logic [7:0] sc);
        press_sel();
        calc_score = sc;
        press_sel();
        tick();
        tick();
        if (state != 3'(ST_GAME_END)) tick();
    endtask

    task automatic play_turn(input logic [7:0] sc);
        press_roll();
        tick();
        finish_turn(sc);
    endtask

    function automatic logic [TW-1:0] score_of(input int p);
        return scores[p*TW +: TW];
    endfunction

    initial begin
        // ---------------- reset values ----------------
        tick(); tick();
        check("rst_state", 32'(state), 32'(ST_INIT));
        check("rst_player", 32'(player), 32'd0);
        check("rst_trig", 32'(roll_trigger), 32'd0);
        check("rst_rollcnt", 32'(roll_cnt), 32'd0);
        check("rst_cat", 32'(category_idx), 32'd0);
        check("rst_round", 32'(round_num), 32'd1);
        check("rst_scores", 32'(scores), 32'd0);
        check("rst_gameover", 32'(game_over), 32'd0);
        check("rst_winner", 32'(winner), 32'd0);
        check("rst_tie", 32'(tie), 32'd0);
        reset_n = 1'b1;
        wait_state(3'(ST_WAIT), 10);

        // ---------------- game 1: roll rules, bonus, mid-game reset ----------------
        press_sel();
        check("sel_no_roll", 32'(state), 32'(ST_WAIT));
        press_roll();
        check("roll_state", 32'(state), 32'(ST_ROLL));
        check("trig_early", 32'(roll_trigger), 32'd0);
        tick();
        check("trig_pulse", 32'(roll_trigger), 32'd1);
        check("rollcnt_1", 32'(roll_cnt), 32'd1);
        check("back_wait", 32'(state), 32'(ST_WAIT));
        tick();
        check("trig_end", 32'(roll_trigger), 32'd0);
        press_roll(); tick();
        check("rollcnt_2", 32'(roll_cnt), 32'd2);
        press_roll(); tick();
        check("auto_select", 32'(state), 32'(ST_SELECT));
        check("rollcnt_3", 32'(roll_cnt), 32'd3);
        press_roll();
        check("roll4_state", 32'(state), 32'(ST_SELECT));
        tick();
        check("roll4_trig", 32'(roll_trigger), 32'd0);
        check("roll4_cnt", 32'(roll_cnt), 32'd3);
        calc_score = 8'd20;
        press_sel();
        check("commit_state", 32'(state), 32'(ST_COMMIT));
        tick();
        check("p0_total_r1", 32'(score_of(0)), 32'd20);
        tick();
        check("next_player", 32'(player), 32'd1);
        tick();
        check("p1_first_cat", 32'(category_idx), 32'd0);
        // roll and select together: roll wins
        btn_roll = 1'b1; btn_sel = 1'b1; tick(); btn_roll = 1'b0; btn_sel = 1'b0;
        check("roll_wins", 32'(state), 32'(ST_ROLL));
        tick();
        finish_turn(8'd5);
        play_turn(8'd5);
        check("round2", 32'(round_num), 32'd2);
        check("p0_cat_r2", 32'(category_idx), 32'd1);
        play_turn(8'd20);
        play_turn(8'd5);
        play_turn(8'd5);
        play_turn(8'd23);
`ifdef YACHT_UPPER_BONUS_EN
        check("p0_bonus", 32'(score_of(0)), 32'd98);
`else
        check("p0_nobonus", 32'(score_of(0)), 32'd63);
`endif
        play_turn(8'd5);
        play_turn(8'd5);
        play_turn(8'd10);
`ifdef YACHT_UPPER_BONUS_EN
        check("p0_no_2nd_bonus", 32'(score_of(0)), 32'd108);
`else
        check("p0_plain_sum", 32'(score_of(0)), 32'd73);
`endif
        check("p1_total_r4", 32'(score_of(1)), 32'd15);
        for (int i = 0; i < 8; i++) play_turn(8'd5);
        press_roll(); tick(); press_sel();
        check("r7_select", 32'(state), 32'(ST_SELECT));
        check("r7_round", 32'(round_num), 32'd7);
        reset_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 32'(ST_INIT));
        check("mid_rst_round", 32'(round_num), 32'd1);
        check("mid_rst_scores", 32'(scores), 32'd0);
        check("mid_rst_rollcnt", 32'(roll_cnt), 32'd0);
        tick();
        reset_n = 1'b1;
        wait_state(3'(ST_WAIT), 10);

        // ---------------- game 2: navigation and tied finish ----------------
        check("g2_cat_start", 32'(category_idx), 32'd0);
        for (int i = 0; i < 30; i++) play_turn(8'd5);
        check("round11", 32'(round_num), 32'd11);
        press_roll(); tick(); press_sel();
        check("r11_first", 32'(category_idx), 32'd10);
        press_next();
        check("next_10_11", 32'(category_idx), 32'd11);
        press_next();
        check("next_wrap", 32'(category_idx), 32'd10);
        press_prev();
        check("prev_wrap", 32'(category_idx), 32'd11);
        press_prev();
        check("prev_11_10", 32'(category_idx), 32'd10);
        btn_next = 1'b1; btn_prev = 1'b1; tick(); btn_next = 1'b0; btn_prev = 1'b0;
        check("next_wins", 32'(category_idx), 32'd11);
        calc_score = 8'd5;
        btn_sel = 1'b1; btn_prev = 1'b1; tick(); btn_sel = 1'b0; btn_prev = 1'b0;
        check("sel_move_state", 32'(state), 32'(ST_COMMIT));
        check("sel_move_ignored", 32'(category_idx), 32'd11);
        tick(); tick(); tick();
        play_turn(8'd5);
        play_turn(8'd5);
        check("r12_first", 32'(category_idx), 32'd10);
        press_roll(); tick(); press_sel();
        press_next();
        check("sole_next", 32'(category_idx), 32'd10);
        press_prev();
        check("sole_prev", 32'(category_idx), 32'd10);
        finish_turn_from_select();
        play_turn(8'd5);
        play_turn(8'd5);
        check("g2_end_state", 32'(state), 32'(ST_GAME_END));
        check("g2_gameover", 32'(game_over), 32'd1);
        check("g2_p0", 32'(score_of(0)), 32'd60);
        check("g2_p1", 32'(score_of(1)), 32'd60);
        check("g2_p2", 32'(score_of(2)), 32'd60);
        check("g2_tie", 32'(tie), 32'd1);
        check("g2_winner", 32'(winner), 32'd0);
        press_sel();
        check("end_sel_ignored", 32'(state), 32'(ST_GAME_END));
        press_next();
        check("end_next_ignored", 32'(state), 32'(ST_GAME_END));
        press_roll();
        check("restart_state", 32'(state), 32'(ST_INIT));
        check("restart_scores", 32'(scores), 32'd0);
        check("restart_round", 32'(round_num), 32'd1);
        check("restart_gameover", 32'(game_over), 32'd0);
        wait_state(3'(ST_WAIT), 10);

        // ---------------- game 3: saturation and clear winner ----------------
        for (int r = 0; r < 12; r++) begin
            play_turn(8'd5);
            play_turn(8'd255);
            play_turn(8'd5);
        end
        check("g3_end_state", 32'(state), 32'(ST_GAME_END));
        check("g3_p1_sat", 32'(score_of(1)), 32'd1023);
        check("g3_p0", 32'(score_of(0)), 32'd60);
        check("g3_p2", 32'(score_of(2)), 32'd60);
        check("g3_winner", 32'(winner), 32'd1);
        check("g3_tie", 32'(tie), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Commit from SELECT with the score already chosen, then return to WAIT
    task automatic finish_turn_from_select();
        calc_score = 8'd5;
        press_sel();
        tick();
        tick();
        tick();
    endtask

    // Hard stop if the run ever stalls
    initial begin
        #200000;
        $display("FAIL timeout observed %0d expected %0d", state, 0);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
